truth_table_sweeper: RTL
========================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N_VARS, default 3, number of Boolean input variables (legal 1..6).
REQ-002 SHALL have parameter N_OUTS, default 2, number of Boolean output functions (legal 1..4).
REQ-003 SHALL have parameter TABLE, width N_OUTS*2^N_VARS, default 16'h0C0C, where bit [o*2^N_VARS+m] is output o at minterm m; the default gives both outputs = ~x&y, with x as MSB.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge active.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request to begin an operation, sampled only in IDLE.
REQ-007 SHALL have port mode, input, 1, sampled with start: 0 = full sweep, 1 = single evaluate.
REQ-008 SHALL have port vec_in, input, N_VARS, minterm to evaluate in single mode.
REQ-009 SHALL have port abort, input, 1, terminates a sweep early.
REQ-010 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-011 SHALL have port valid, output, 1, minterm/f_out qualifier.
REQ-012 SHALL have port minterm, output, N_VARS, variable vector presented, MSB = first variable (x).
REQ-013 SHALL have port f_out, output, N_OUTS, function values at minterm.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port cnt, output, N_OUTS*(N_VARS+1), per-output ones count packed with output o at [o*(N_VARS+1) +: N_VARS+1].

Function
REQ-016 SHALL implement the FSM states IDLE, SWEEP, EVAL and DONE; all outputs SHALL be registered.
REQ-017 SHALL, on IDLE with start=1 and mode=0 at edge T, enter SWEEP, clear cnt, and present minterm=0 with valid=1 at T+1.
REQ-018 SHALL, in SWEEP, increment minterm by 1 per cycle with valid=1, with f_out[o]=TABLE[o*2^N_VARS+minterm].
REQ-019 SHALL, after minterm 2^N_VARS-1 is presented, enter DONE with done=1, valid=0, and minterm held; the full sweep SHALL take 2^N_VARS valid cycles followed by 1 done cycle.
REQ-020 SHALL return DONE to IDLE unconditionally on the next edge.
REQ-021 SHALL, on IDLE with start=1 and mode=1, capture vec_in and enter EVAL, presenting valid=1 and done=1 together one cycle later; the next state SHALL be IDLE.
REQ-022 SHALL count every valid cycle into cnt, so that cnt equals the number of ones of each output over the minterms presented; cnt SHALL hold its value until the next accepted start.
REQ-023 SHALL, when abort=1 in a SWEEP cycle, still count the current minterm, then enter DONE on the next edge; abort SHALL be ignored outside SWEEP.
REQ-024 SHALL ignore start while busy=1; mode and vec_in SHALL be don't-care except at an accepted start.
REQ-025 SHALL NOT wrap minterm past 2^N_VARS-1; N_VARS-bit arithmetic is used, and termination is detected on the all-ones value.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, force state=IDLE, busy=0, valid=0, done=0, minterm=0, f_out=0 and cnt=0, from any state including mid-sweep.
REQ-027 SHALL give reset priority over start and abort in the same cycle.

Configuration
REQ-028 SHALL, with macro TRUTH_TABLE_SWEEPER_ONES_COUNT_EN defined, implement cnt as specified in REQ-022.
REQ-029 SHALL, without TRUTH_TABLE_SWEEPER_ONES_COUNT_EN, drive cnt constantly to 0, synthesise no counter logic, and leave all other behaviour unchanged.

Verification
REQ-030 Default parameters, start=1 mode=0 -> 8 valid cycles with minterm 0..7 and f_out 00,00,11,11,00,00,00,00, then done=1 with cnt=8'h22, then busy=0.
REQ-031 start=1 mode=1 vec_in=3'b011 -> one cycle later valid=1, done=1, minterm=3, f_out=2'b11, cnt=8'h11; next cycle busy=0.
REQ-032 Sweep with abort=1 while minterm=2 is presented -> next cycle done=1 with cnt=8'h11 and minterm held at 2.
REQ-033 reset=1 while minterm=5 is presented -> next cycle all outputs 0 and state IDLE; a following start gives a fresh sweep starting at minterm 0.
REQ-034 start pulsed during SWEEP and in the same cycle as reset -> no restart, and the sweep sequence is unaffected or reset wins respectively.
REQ-035 Build without TRUTH_TABLE_SWEEPER_ONES_COUNT_EN, run the REQ-030 stimulus -> identical valid/f_out/done sequence and cnt=0 throughout.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks or single-evaluates a packed Boolean table.
// Define TRUTH_TABLE_SWEEPER_ONES_COUNT_EN to build the per-output ones counters.
module truth_table_sweeper #(
    parameter int N_VARS = 3,
    parameter int N_OUTS = 2,
    parameter logic [N_OUTS*(2**N_VARS)-1:0] TABLE = 16'h0C0C
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic [N_VARS-1:0]            vec_in,
    input  logic                         abort,
    output logic                         busy,
    output logic                         valid,
    output logic [N_VARS-1:0]            minterm,
    output logic [N_OUTS-1:0]            f_out,
    output logic                         done,
    output logic [N_OUTS*(N_VARS+1)-1:0] cnt
);

    localparam int NM = 2**N_VARS;
    localparam int CW = N_VARS + 1;
    localparam logic [N_OUTS-1:0][NM-1:0] TT = TABLE;

    typedef enum logic [1:0] {IDLE, SWEEP, EVAL, DONE} state_t;

    state_t              state_q, state_d;
    logic [N_VARS-1:0]   min_d;
    logic [N_OUTS-1:0]   f_d;
    logic                valid_d, done_d, busy_d;
    logic                load;
    logic                clr;

    function automatic logic [N_OUTS-1:0] lookup(input logic [N_VARS-1:0] m);
        logic [N_OUTS-1:0] r;
        r = '0;
        for (int o = 0; o < N_OUTS; o++)
            r[o] = TT[o][m];
        return r;
    endfunction

    // load marks an edge that presents a new minterm; clr marks an accepted start
    always_comb begin
        state_d = state_q;
        min_d   = minterm;
        f_d     = f_out;
        valid_d = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    load    = 1'b1;
                    valid_d = 1'b1;
                    if (mode) begin
                        state_d = EVAL;
                        min_d   = vec_in;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SWEEP;
                        min_d   = '0;
                    end
                end
            end
            SWEEP: begin
                if (abort || (&minterm)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    load    = 1'b1;
                    valid_d = 1'b1;
                    min_d   = minterm + 1'b1;
                end
            end
            EVAL:    state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load)
            f_d = lookup(min_d);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b0;
            minterm <= '0;
            f_out   <= '0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            valid   <= valid_d;
            done    <= done_d;
            minterm <= min_d;
            f_out   <= f_d;
        end
    end

`ifdef TRUTH_TABLE_SWEEPER_ONES_COUNT_EN
    logic [N_OUTS*CW-1:0] cnt_q;

    // count includes the minterm being presented in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            for (int o = 0; o < N_OUTS; o++)
                cnt_q[o*CW +: CW] <= (clr ? '0 : cnt_q[o*CW +: CW])
                                     + {{N_VARS{1'b0}}, f_d[o]};
        end
    end

    assign cnt = cnt_q;
`else
    assign cnt = '0;
`endif

endmodule
